// File: rtl/pwm_duty_ramp_if.sv
// Handshake and duty-word bundle between a target/period source and the duty ramp block.
// The master drives targets, step and period strobes; the slave returns the slewed duty word.
interface pwm_duty_ramp_if #(
    parameter int width = 32
);
    logic [width-1:0] target_in;
    logic             target_valid;
    logic             target_ready;
    logic [width-1:0] step;
    logic             period_end;
    logic [width-1:0] duty_out;
    logic             at_target;
    logic             ramping;

    modport master (
        output target_in, target_valid, step, period_end,
        input  target_ready, duty_out, at_target, ramping
    );

    modport slave (
        input  target_in, target_valid, step, period_end,
        output target_ready, duty_out, at_target, ramping
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Slews a registered duty word toward an accepted target by a programmable step,
// updating only on PWM period boundaries so the generator never sees a mid-period change.
module pwm_duty_ramp #(
    parameter int               width      = 32,
    parameter int               UPDATE_DIV = 1,
    parameter logic [width-1:0] RESET_DUTY = '0
) (
    input logic            clk,
    input logic            reset,
    pwm_duty_ramp_if.slave bus
);
    localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    state_t           state_reg, state_next;
    logic [width-1:0] duty_reg, duty_next;
    logic [width-1:0] target_reg, target_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             at_target_reg, at_target_next;
    logic             update;
    logic [width:0]   sum_wide;
    logic [width:0]   diff_wide;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            duty_reg      <= RESET_DUTY;
            target_reg    <= RESET_DUTY;
            div_reg       <= '0;
            at_target_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            duty_reg      <= duty_next;
            target_reg    <= target_next;
            div_reg       <= div_next;
            at_target_reg <= at_target_next;
        end
    end

    always_comb begin
        target_next    = target_reg;
        duty_next      = duty_reg;
        div_next       = div_reg;
        state_next     = state_reg;
        at_target_next = at_target_reg;
        update         = 1'b0;
        // Extra top bit catches overflow going up and borrow going down.
        sum_wide       = {1'b0, duty_reg} + {1'b0, bus.step};
        diff_wide      = {1'b0, duty_reg} - {1'b0, bus.step};

        if (bus.target_valid) begin
            target_next = bus.target_in;
        end

        if (state_reg != IDLE && bus.period_end) begin
            if (div_reg == DIV_LAST) begin
                update   = 1'b1;
                div_next = '0;
            end else begin
                div_next = div_reg + 1'b1;
            end
        end

        // The step always moves toward the target held before this edge's handshake.
        if (update) begin
            if (bus.step == '0) begin
                duty_next = target_reg;
            end else if (state_reg == RAMP_UP) begin
                duty_next = (sum_wide >= {1'b0, target_reg}) ? target_reg : sum_wide[width-1:0];
            end else if (diff_wide[width] || diff_wide[width-1:0] <= target_reg) begin
                duty_next = target_reg;
            end else begin
                duty_next = diff_wide[width-1:0];
            end
        end

        if (duty_next == target_next) begin
            state_next = IDLE;
            div_next   = '0;
        end else if (target_next > duty_next) begin
            state_next = RAMP_UP;
        end else begin
            state_next = RAMP_DOWN;
        end
        at_target_next = (duty_next == target_next);
    end

    assign bus.target_ready = !reset;
    assign bus.duty_out     = duty_reg;
    assign bus.at_target    = at_target_reg;
    assign bus.ramping      = !at_target_reg;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: one instance with UPDATE_DIV=1 and one with UPDATE_DIV=3,
// both 8 bits wide, sharing clock and reset.
module tb_pwm_duty_ramp;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp_if #(.width(8)) ifa ();
    pwm_duty_ramp_if #(.width(8)) ifb ();

    pwm_duty_ramp #(.width(8), .UPDATE_DIV(1), .RESET_DUTY(8'd0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    pwm_duty_ramp #(.width(8), .UPDATE_DIV(3), .RESET_DUTY(8'd0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s obs=%0d", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe period_end for one clock, then let the period run out (10 clk per period).
    task automatic pulse_a();
        @(negedge clk); ifa.period_end = 1'b1;
        @(negedge clk); ifa.period_end = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_b();
        @(negedge clk); ifb.period_end = 1'b1;
        @(negedge clk); ifb.period_end = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] t, input logic [7:0] s);
        @(negedge clk);
        ifa.target_in = t; ifa.step = s; ifa.target_valid = 1'b1;
        @(negedge clk);
        ifa.target_valid = 1'b0;
    endtask

    // Jump instance A straight to a value using step=0.
    task automatic jump_a(input logic [7:0] t);
        send_a(t, 8'd0);
        pulse_a();
    endtask

    initial begin
        reset = 1'b1;
        ifa.target_in = '0; ifa.target_valid = 1'b0; ifa.step = '0; ifa.period_end = 1'b0;
        ifb.target_in = '0; ifb.target_valid = 1'b0; ifb.step = '0; ifb.period_end = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_duty", 32'(ifa.duty_out), 0);
        chk("rst_at_target", 32'(ifa.at_target), 1);
        chk("rst_ramping", 32'(ifa.ramping), 0);
        chk("rst_ready", 32'(ifa.target_ready), 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(ifa.target_ready), 1);

        // Ramp up 0 -> 100 by 30.
        send_a(8'd100, 8'd30);
        chk("up_accept_duty", 32'(ifa.duty_out), 0);
        chk("up_accept_ramping", 32'(ifa.ramping), 1);
        pulse_a(); chk("up_s1", 32'(ifa.duty_out), 30);
        chk("up_s1_at_target", 32'(ifa.at_target), 0);
        pulse_a(); chk("up_s2", 32'(ifa.duty_out), 60);
        pulse_a(); chk("up_s3", 32'(ifa.duty_out), 90);
        pulse_a(); chk("up_s4", 32'(ifa.duty_out), 100);
        chk("up_s4_at_target", 32'(ifa.at_target), 1);
        chk("up_s4_ramping", 32'(ifa.ramping), 0);

        // Saturation at the top of the range.
        jump_a(8'd250);
        chk("jump_250", 32'(ifa.duty_out), 250);
        send_a(8'd255, 8'd20);
        pulse_a(); chk("sat_255", 32'(ifa.duty_out), 255);
        chk("sat_at_target", 32'(ifa.at_target), 1);

        // Ramp down without underflow, then a step=0 jump up.
        jump_a(8'd100);
        send_a(8'd5, 8'd40);
        pulse_a(); chk("dn_s1", 32'(ifa.duty_out), 60);
        pulse_a(); chk("dn_s2", 32'(ifa.duty_out), 20);
        pulse_a(); chk("dn_s3", 32'(ifa.duty_out), 5);
        chk("dn_at_target", 32'(ifa.at_target), 1);
        send_a(8'd200, 8'd0);
        pulse_a(); chk("step0_jump", 32'(ifa.duty_out), 200);

        // Reversal: new target accepted on the same edge as a strobe.
        jump_a(8'd60);
        send_a(8'd200, 8'd30);
        @(negedge clk);
        ifa.target_in = 8'd10; ifa.target_valid = 1'b1; ifa.period_end = 1'b1;
        @(negedge clk);
        ifa.target_valid = 1'b0; ifa.period_end = 1'b0;
        chk("rev_old_target", 32'(ifa.duty_out), 90);
        chk("rev_ramping", 32'(ifa.ramping), 1);
        pulse_a(); chk("rev_s1", 32'(ifa.duty_out), 60);
        pulse_a(); chk("rev_s2", 32'(ifa.duty_out), 30);
        pulse_a(); chk("rev_s3", 32'(ifa.duty_out), 10);
        chk("rev_at_target", 32'(ifa.at_target), 1);

        // Reset mid-ramp at duty 90.
        jump_a(8'd60);
        send_a(8'd200, 8'd30);
        pulse_a(); chk("mid_90", 32'(ifa.duty_out), 90);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ifa.target_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_duty", 32'(ifa.duty_out), 0);
        chk("mid_rst_at_target", 32'(ifa.at_target), 1);
        chk("mid_rst_ramping", 32'(ifa.ramping), 0);
        pulse_a(); chk("post_rst_strobe", 32'(ifa.duty_out), 0);
        chk("post_rst_at_target", 32'(ifa.at_target), 1);

        // UPDATE_DIV=3: idle strobes must not pre-load the divider.
        pulse_b(); pulse_b();
        @(negedge clk);
        ifb.target_in = 8'd90; ifb.step = 8'd30; ifb.target_valid = 1'b1;
        @(negedge clk);
        ifb.target_valid = 1'b0;
        pulse_b(); chk("div_s1", 32'(ifb.duty_out), 0);
        pulse_b(); chk("div_s2", 32'(ifb.duty_out), 0);
        pulse_b(); chk("div_s3", 32'(ifb.duty_out), 30);
        pulse_b(); chk("div_s4", 32'(ifb.duty_out), 30);
        pulse_b(); chk("div_s5", 32'(ifb.duty_out), 30);
        pulse_b(); chk("div_s6", 32'(ifb.duty_out), 60);
        pulse_b(); chk("div_s7", 32'(ifb.duty_out), 60);
        pulse_b(); chk("div_s8", 32'(ifb.duty_out), 60);
        pulse_b(); chk("div_s9", 32'(ifb.duty_out), 90);
        chk("div_at_target", 32'(ifb.at_target), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
